// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC motor supervisor: state encodings,
// clock-derived default periods and a counter sizing helper.
package bldc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RAMP    = 3'd1,
      ST_RUN     = 3'd2,
      ST_BACKOFF = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_e;

   localparam int unsigned CLK_FREQ_HZ              = 18_432_000;
   localparam int unsigned SAMPLE_RATE_HZ           = 1_000;
   localparam int unsigned BACKOFF_RATE_HZ          = 100;
   localparam int unsigned DEF_SAMPLE_PERIOD_CYCLES = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
   localparam int unsigned DEF_RETRY_BACKOFF_CYCLES = CLK_FREQ_HZ / BACKOFF_RATE_HZ;

   // Bits needed for a counter that runs 0..n-1, never narrower than one bit
   function automatic int unsigned counter_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bldc_sample_timer.sv
// Free-running sample timer: captures the live encoder and hall counts on
// the terminal count and pulses the counter clears / snapshot strobe in the
// following cycle.
module bldc_sample_timer
   import bldc_pkg::*;
#(
   parameter int unsigned SAMPLE_PERIOD_CYCLES = DEF_SAMPLE_PERIOD_CYCLES,
   parameter int unsigned ENCODER_COUNT_WIDTH  = 15,
   parameter int unsigned HALL_COUNT_WIDTH     = 7
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [ENCODER_COUNT_WIDTH-1:0] enc_count,
   input  logic [HALL_COUNT_WIDTH-1:0]    hall_count,
   output logic [ENCODER_COUNT_WIDTH-1:0] snap_enc,
   output logic [HALL_COUNT_WIDTH-1:0]    snap_hall,
   output logic                           snap_valid,
   output logic                           reset_enc_count,
   output logic                           reset_hall_count
);

   localparam int unsigned    CNT_W    = counter_width(SAMPLE_PERIOD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD_CYCLES - 1);

   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [ENCODER_COUNT_WIDTH-1:0] snap_enc_q, snap_enc_d;
   logic [HALL_COUNT_WIDTH-1:0]    snap_hall_q, snap_hall_d;
   logic                           pulse_q, pulse_d;
   logic                           terminal;

   // Next-state: wrap the counter, capture on terminal count, strobe one cycle later
   always_comb begin
      terminal    = (cnt_q == CNT_LAST);
      cnt_d       = terminal ? '0 : cnt_q + 1'b1;
      snap_enc_d  = snap_enc_q;
      snap_hall_d = snap_hall_q;
      pulse_d     = terminal;
      if (terminal) begin
         snap_enc_d  = enc_count;
         snap_hall_d = hall_count;
      end
   end

   // Sample timer and snapshot registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= '0;
         snap_enc_q  <= '0;
         snap_hall_q <= '0;
         pulse_q     <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         snap_enc_q  <= snap_enc_d;
         snap_hall_q <= snap_hall_d;
         pulse_q     <= pulse_d;
      end
   end

   assign snap_enc         = snap_enc_q;
   assign snap_hall        = snap_hall_q;
   assign snap_valid       = pulse_q;
   assign reset_enc_count  = pulse_q;
   assign reset_hall_count = pulse_q;

endmodule

// File: rtl/bldc_motor_supervisor.sv
// Per-motor sequencer: ramps duty toward the commanded target, debounces
// loss of connection, retries with backoff and latches a lockout after
// repeated faults. Periodic count snapshots come from bldc_sample_timer.
module bldc_motor_supervisor
   import bldc_pkg::*;
#(
   parameter int unsigned                  DUTY_CYCLE_WIDTH     = 9,
   parameter logic [DUTY_CYCLE_WIDTH-1:0]  MAX_DUTY_CYCLE       = 'h1FF,
   parameter int unsigned                  ENCODER_COUNT_WIDTH  = 15,
   parameter int unsigned                  HALL_COUNT_WIDTH     = 7,
   parameter int unsigned                  RAMP_STEP            = 8,
   parameter int unsigned                  RAMP_TICK_CYCLES     = 1024,
   parameter int unsigned                  SAMPLE_PERIOD_CYCLES = DEF_SAMPLE_PERIOD_CYCLES,
   parameter int unsigned                  DISCONNECT_DEBOUNCE  = 16,
   parameter int unsigned                  RETRY_BACKOFF_CYCLES = DEF_RETRY_BACKOFF_CYCLES,
   parameter int unsigned                  MAX_RETRIES          = 3
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           cmd_en,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [DUTY_CYCLE_WIDTH-1:0]    cmd_duty,
   input  logic                           clear_fault,
   input  logic                           connected,
   input  logic [ENCODER_COUNT_WIDTH-1:0] enc_count,
   input  logic [HALL_COUNT_WIDTH-1:0]    hall_count,
   output logic                           motor_en,
   output logic [DUTY_CYCLE_WIDTH-1:0]    motor_duty,
   output logic                           reset_enc_count,
   output logic                           reset_hall_count,
   output logic [ENCODER_COUNT_WIDTH-1:0] snap_enc,
   output logic [HALL_COUNT_WIDTH-1:0]    snap_hall,
   output logic                           snap_valid,
   output logic [2:0]                     state,
   output logic                           fault_latched
);

   localparam int unsigned DW      = DUTY_CYCLE_WIDTH;
   localparam int unsigned DWX     = DUTY_CYCLE_WIDTH + 1;
   localparam int unsigned TICK_W  = counter_width(RAMP_TICK_CYCLES);
   localparam int unsigned DEB_W   = counter_width(DISCONNECT_DEBOUNCE + 1);
   localparam int unsigned BO_W    = counter_width(RETRY_BACKOFF_CYCLES);
   localparam int unsigned RETRY_W = counter_width(MAX_RETRIES + 1);

   localparam logic [DWX-1:0]     STEP_EXT    = DWX'(RAMP_STEP);
   localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(RAMP_TICK_CYCLES - 1);
   localparam logic [DEB_W-1:0]   DEB_LAST    = DEB_W'(DISCONNECT_DEBOUNCE - 1);
   localparam logic [BO_W-1:0]    BO_LAST     = BO_W'(RETRY_BACKOFF_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

   state_e             state_q, state_d;
   logic [DW-1:0]      duty_q, duty_d;
   logic [DW-1:0]      target_q, target_d;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [DEB_W-1:0]   deb_q, deb_d;
   logic [BO_W-1:0]    bo_q, bo_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               motor_en_q, motor_en_d;
   logic               fault_q, fault_d;

   logic               accept;
   logic [DW-1:0]      clamped_duty;
   logic [DWX-1:0]     ramp_sum;
   logic               tick_done;
   logic               deb_hit;

   // Handshake, clamp, ramp sum and debounce expiry shared by the FSM
   always_comb begin
      cmd_ready    = (state_q != ST_LOCKOUT);
      accept       = cmd_valid && cmd_ready;
      clamped_duty = (cmd_duty > MAX_DUTY_CYCLE) ? MAX_DUTY_CYCLE : cmd_duty;
      ramp_sum     = {1'b0, duty_q} + STEP_EXT;
      tick_done    = (tick_q == TICK_LAST);
      deb_hit      = motor_en_q && !connected && (deb_q == DEB_LAST);
   end

   // Sequencer next-state: target capture, debounce, ramp, backoff and lockout
   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      target_d = target_q;
      tick_d   = tick_q;
      bo_d     = bo_q;
      retry_d  = retry_q;

      if (accept) begin
         target_d = clamped_duty;
      end

      if (connected || !motor_en_q) begin
         deb_d = '0;
      end else begin
         deb_d = deb_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            duty_d  = '0;
            retry_d = '0;
            tick_d  = '0;
            bo_d    = '0;
            if (cmd_en && connected) begin
               state_d = ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (!cmd_en) begin
               state_d = ST_IDLE;
               duty_d  = '0;
            end else if (deb_hit) begin
               state_d = ST_BACKOFF;
               duty_d  = '0;
               bo_d    = '0;
               retry_d = retry_q + 1'b1;
            end else if (duty_q >= target_q) begin
               duty_d  = target_q;
               state_d = ST_RUN;
            end else if (tick_done) begin
               tick_d = '0;
               if (ramp_sum >= {1'b0, target_q}) begin
                  duty_d  = target_q;
                  state_d = ST_RUN;
               end else begin
                  duty_d = ramp_sum[DW-1:0];
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (!cmd_en) begin
               state_d = ST_IDLE;
               duty_d  = '0;
            end else if (deb_hit) begin
               state_d = ST_BACKOFF;
               duty_d  = '0;
               bo_d    = '0;
               retry_d = retry_q + 1'b1;
            end else if (target_q > duty_q) begin
               state_d = ST_RAMP;
               tick_d  = '0;
            end else begin
               duty_d = target_q;
            end
         end
         ST_BACKOFF: begin
            duty_d = '0;
            if (!cmd_en) begin
               state_d = ST_IDLE;
            end else if (bo_q == BO_LAST) begin
               bo_d = '0;
               if (retry_q >= RETRY_LIMIT) begin
                  state_d = ST_LOCKOUT;
               end else if (connected) begin
                  state_d = ST_RAMP;
                  tick_d  = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               bo_d = bo_q + 1'b1;
            end
         end
         ST_LOCKOUT: begin
            duty_d = '0;
            if (clear_fault) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            duty_d  = '0;
         end
      endcase

      motor_en_d = (state_d == ST_RAMP) || (state_d == ST_RUN);
      fault_d    = (state_d == ST_LOCKOUT);
   end

   // Sequencer registers; reset drops motor_en without waiting for a clock
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         duty_q     <= '0;
         target_q   <= '0;
         tick_q     <= '0;
         deb_q      <= '0;
         bo_q       <= '0;
         retry_q    <= '0;
         motor_en_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         target_q   <= target_d;
         tick_q     <= tick_d;
         deb_q      <= deb_d;
         bo_q       <= bo_d;
         retry_q    <= retry_d;
         motor_en_q <= motor_en_d;
         fault_q    <= fault_d;
      end
   end

   assign motor_en      = motor_en_q;
   assign motor_duty    = duty_q;
   assign state         = state_q;
   assign fault_latched = fault_q;

   bldc_sample_timer #(
      .SAMPLE_PERIOD_CYCLES (SAMPLE_PERIOD_CYCLES),
      .ENCODER_COUNT_WIDTH  (ENCODER_COUNT_WIDTH),
      .HALL_COUNT_WIDTH     (HALL_COUNT_WIDTH)
   ) u_sample_timer (
      .clk              (clk),
      .reset_n          (reset_n),
      .enc_count        (enc_count),
      .hall_count       (hall_count),
      .snap_enc         (snap_enc),
      .snap_hall        (snap_hall),
      .snap_valid       (snap_valid),
      .reset_enc_count  (reset_enc_count),
      .reset_hall_count (reset_hall_count)
   );

endmodule

// File: tb/tb_bldc_motor_supervisor.sv
// Directed bench for bldc_motor_supervisor with short timing parameters.
module tb_bldc_motor_supervisor;

   localparam int DW = 10;
   localparam int EW = 15;
   localparam int HW = 7;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RAMP    = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_BACKOFF = 3'd3;
   localparam logic [2:0] S_LOCKOUT = 3'd4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cmd_en;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [DW-1:0] cmd_duty;
   logic          clear_fault;
   logic          connected;
   logic [EW-1:0] enc_count;
   logic [HW-1:0] hall_count;
   logic          motor_en;
   logic [DW-1:0] motor_duty;
   logic          reset_enc_count;
   logic          reset_hall_count;
   logic [EW-1:0] snap_enc;
   logic [HW-1:0] snap_hall;
   logic          snap_valid;
   logic [2:0]    state;
   logic          fault_latched;

   int errors = 0;
   int checks = 0;

   bldc_motor_supervisor #(
      .DUTY_CYCLE_WIDTH     (DW),
      .MAX_DUTY_CYCLE       (10'h100),
      .ENCODER_COUNT_WIDTH  (EW),
      .HALL_COUNT_WIDTH     (HW),
      .RAMP_STEP            (8),
      .RAMP_TICK_CYCLES     (4),
      .SAMPLE_PERIOD_CYCLES (100),
      .DISCONNECT_DEBOUNCE  (4),
      .RETRY_BACKOFF_CYCLES (20),
      .MAX_RETRIES          (3)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .cmd_en           (cmd_en),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_duty         (cmd_duty),
      .clear_fault      (clear_fault),
      .connected        (connected),
      .enc_count        (enc_count),
      .hall_count       (hall_count),
      .motor_en         (motor_en),
      .motor_duty       (motor_duty),
      .reset_enc_count  (reset_enc_count),
      .reset_hall_count (reset_hall_count),
      .snap_enc         (snap_enc),
      .snap_hall        (snap_hall),
      .snap_valid       (snap_valid),
      .state            (state),
      .fault_latched    (fault_latched)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Advance one clock and settle just past the rising edge
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Hold connected low for n clocks
   task automatic lose_connection(input int n);
      connected = 1'b0;
      step(n);
   endtask

   task automatic test_reset;
      reset_n     = 1'b0;
      cmd_en      = 1'b0;
      cmd_valid   = 1'b0;
      cmd_duty    = '0;
      clear_fault = 1'b0;
      connected   = 1'b0;
      enc_count   = '0;
      hall_count  = '0;
      step(3);
      checks++;
      if (state !== S_IDLE || motor_en !== 1'b0 || motor_duty !== '0 || fault_latched !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got state=%0d en=%0b duty=%0d fault=%0b required 0 0 0 0",
                  state, motor_en, motor_duty, fault_latched);
      end
      checks++;
      if (snap_valid !== 1'b0 || reset_enc_count !== 1'b0 || reset_hall_count !== 1'b0 ||
          snap_enc !== '0 || snap_hall !== '0) begin
         errors++;
         $display("[TB] FAIL reset_snap: got valid=%0b rst=%0b/%0b enc=%0d hall=%0d required all 0",
                  snap_valid, reset_enc_count, reset_hall_count, snap_enc, snap_hall);
      end
      reset_n = 1'b1;
      step(1);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL idle_ready: got %0b required 1", cmd_ready);
      end
   endtask

   task automatic test_snapshot;
      logic early;
      reset_n    = 1'b0;
      enc_count  = 15'd1234;
      hall_count = 7'd17;
      step(1);
      reset_n = 1'b1;
      early   = 1'b0;
      for (int i = 1; i <= 99; i++) begin
         step(1);
         if (snap_valid !== 1'b0 || reset_enc_count !== 1'b0) early = 1'b1;
      end
      checks++;
      if (early !== 1'b0) begin
         errors++;
         $display("[TB] FAIL snap_early: got pulse before cycle 100 required none");
      end
      step(1);
      checks++;
      if (snap_valid !== 1'b1 || reset_enc_count !== 1'b1 || reset_hall_count !== 1'b1) begin
         errors++;
         $display("[TB] FAIL snap_pulse: got valid=%0b rst=%0b/%0b required 1 1 1",
                  snap_valid, reset_enc_count, reset_hall_count);
      end
      checks++;
      if (snap_enc !== 15'd1234 || snap_hall !== 7'd17) begin
         errors++;
         $display("[TB] FAIL snap_value: got enc=%0d hall=%0d required 1234 17", snap_enc, snap_hall);
      end
      enc_count  = 15'd4321;
      hall_count = 7'd5;
      step(1);
      checks++;
      if (snap_valid !== 1'b0 || reset_enc_count !== 1'b0 || reset_hall_count !== 1'b0 ||
          snap_enc !== 15'd1234) begin
         errors++;
         $display("[TB] FAIL snap_one_cycle: got valid=%0b rst=%0b/%0b enc=%0d required 0 0 0 1234",
                  snap_valid, reset_enc_count, reset_hall_count, snap_enc);
      end
      step(98);
      checks++;
      if (snap_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL snap_gap: got valid=%0b at cycle 199 required 0", snap_valid);
      end
      step(1);
      checks++;
      if (snap_valid !== 1'b1 || snap_enc !== 15'd4321 || snap_hall !== 7'd5) begin
         errors++;
         $display("[TB] FAIL snap_repeat: got valid=%0b enc=%0d hall=%0d required 1 4321 5",
                  snap_valid, snap_enc, snap_hall);
      end
   endtask

   task automatic test_ramp;
      cmd_valid = 1'b1;
      cmd_duty  = 10'd20;
      step(1);
      cmd_valid = 1'b0;
      cmd_en    = 1'b1;
      connected = 1'b1;
      step(1);
      checks++;
      if (state !== S_RAMP || motor_en !== 1'b1 || motor_duty !== 10'd0) begin
         errors++;
         $display("[TB] FAIL ramp_entry: got state=%0d en=%0b duty=%0d required 1 1 0",
                  state, motor_en, motor_duty);
      end
      step(3);
      checks++;
      if (motor_duty !== 10'd0 || motor_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ramp_hold: got duty=%0d en=%0b required 0 1", motor_duty, motor_en);
      end
      step(1);
      checks++;
      if (motor_duty !== 10'd8 || state !== S_RAMP || motor_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ramp_8: got duty=%0d state=%0d en=%0b required 8 1 1",
                  motor_duty, state, motor_en);
      end
      step(4);
      checks++;
      if (motor_duty !== 10'd16 || state !== S_RAMP || motor_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ramp_16: got duty=%0d state=%0d en=%0b required 16 1 1",
                  motor_duty, state, motor_en);
      end
      step(3);
      checks++;
      if (motor_duty !== 10'd16 || state !== S_RAMP) begin
         errors++;
         $display("[TB] FAIL ramp_pre20: got duty=%0d state=%0d required 16 1", motor_duty, state);
      end
      step(1);
      checks++;
      if (motor_duty !== 10'd20 || state !== S_RUN || motor_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ramp_20_run: got duty=%0d state=%0d en=%0b required 20 2 1",
                  motor_duty, state, motor_en);
      end
   endtask

   task automatic test_decrease_clamp;
      int waited;
      cmd_valid = 1'b1;
      cmd_duty  = 10'd5;
      step(1);
      cmd_valid = 1'b0;
      step(1);
      checks++;
      if (motor_duty !== 10'd5 || state !== S_RUN) begin
         errors++;
         $display("[TB] FAIL decrease: got duty=%0d state=%0d required 5 2", motor_duty, state);
      end
      cmd_valid = 1'b1;
      cmd_duty  = 10'h3FF;
      step(1);
      cmd_valid = 1'b0;
      step(1);
      checks++;
      if (state !== S_RAMP || motor_duty !== 10'd5) begin
         errors++;
         $display("[TB] FAIL clamp_ramp_entry: got state=%0d duty=%0d required 1 5", state, motor_duty);
      end
      waited = 0;
      while (state !== S_RUN && waited < 200) begin
         step(1);
         waited++;
      end
      checks++;
      if (state !== S_RUN || motor_duty !== 10'h100 || waited !== 128) begin
         errors++;
         $display("[TB] FAIL clamp_final: got state=%0d duty=%0d after %0d clocks required 2 256 after 128",
                  state, motor_duty, waited);
      end
   endtask

   task automatic test_debounce;
      lose_connection(3);
      checks++;
      if (state !== S_RUN || motor_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL debounce_3: got state=%0d en=%0b required 2 1", state, motor_en);
      end
      connected = 1'b1;
      step(1);
      lose_connection(3);
      checks++;
      if (state !== S_RUN) begin
         errors++;
         $display("[TB] FAIL debounce_clear: got state=%0d required 2", state);
      end
      step(1);
      checks++;
      if (state !== S_BACKOFF || motor_en !== 1'b0 || motor_duty !== 10'd0) begin
         errors++;
         $display("[TB] FAIL debounce_4: got state=%0d en=%0b duty=%0d required 3 0 0",
                  state, motor_en, motor_duty);
      end
      connected = 1'b1;
      step(19);
      checks++;
      if (state !== S_BACKOFF) begin
         errors++;
         $display("[TB] FAIL backoff_hold: got state=%0d required 3", state);
      end
      step(1);
      checks++;
      if (state !== S_RAMP || motor_en !== 1'b1 || motor_duty !== 10'd0) begin
         errors++;
         $display("[TB] FAIL backoff_retry: got state=%0d en=%0b duty=%0d required 1 1 0",
                  state, motor_en, motor_duty);
      end
   endtask

   task automatic test_lockout;
      lose_connection(4);
      connected = 1'b1;
      step(20);
      checks++;
      if (state !== S_RAMP) begin
         errors++;
         $display("[TB] FAIL second_retry: got state=%0d required 1", state);
      end
      lose_connection(4);
      connected = 1'b1;
      step(19);
      checks++;
      if (state !== S_BACKOFF) begin
         errors++;
         $display("[TB] FAIL third_backoff: got state=%0d required 3", state);
      end
      step(1);
      checks++;
      if (state !== S_LOCKOUT || fault_latched !== 1'b1 || cmd_ready !== 1'b0 || motor_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lockout: got state=%0d fault=%0b ready=%0b en=%0b required 4 1 0 0",
                  state, fault_latched, cmd_ready, motor_en);
      end
      cmd_valid = 1'b1;
      cmd_duty  = 10'd3;
      step(1);
      cmd_valid = 1'b0;
      step(3);
      checks++;
      if (state !== S_LOCKOUT || fault_latched !== 1'b1) begin
         errors++;
         $display("[TB] FAIL lockout_hold: got state=%0d fault=%0b required 4 1", state, fault_latched);
      end
      clear_fault = 1'b1;
      step(1);
      clear_fault = 1'b0;
      checks++;
      if (state !== S_IDLE || fault_latched !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL clear_fault: got state=%0d fault=%0b ready=%0b required 0 0 1",
                  state, fault_latched, cmd_ready);
      end
      step(5);
      checks++;
      if (state !== S_RAMP || motor_duty !== 10'd8) begin
         errors++;
         $display("[TB] FAIL ignored_cmd: got state=%0d duty=%0d required 1 8", state, motor_duty);
      end
      lose_connection(4);
      connected = 1'b1;
      step(20);
      checks++;
      if (state !== S_RAMP) begin
         errors++;
         $display("[TB] FAIL retry_cleared: got state=%0d required 1", state);
      end
   endtask

   task automatic test_priority;
      lose_connection(3);
      checks++;
      if (state !== S_RAMP) begin
         errors++;
         $display("[TB] FAIL prio_pre: got state=%0d required 1", state);
      end
      cmd_en = 1'b0;
      step(1);
      checks++;
      if (state !== S_IDLE || motor_en !== 1'b0 || motor_duty !== 10'd0) begin
         errors++;
         $display("[TB] FAIL prio_idle: got state=%0d en=%0b duty=%0d required 0 0 0",
                  state, motor_en, motor_duty);
      end
      cmd_en    = 1'b1;
      connected = 1'b1;
      step(1);
      checks++;
      if (state !== S_RAMP || motor_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL prio_restart: got state=%0d en=%0b required 1 1", state, motor_en);
      end
   endtask

   task automatic test_reset_mid_ramp;
      step(4);
      checks++;
      if (motor_duty !== 10'd8 || state !== S_RAMP) begin
         errors++;
         $display("[TB] FAIL mid_ramp_pre: got duty=%0d state=%0d required 8 1", motor_duty, state);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (state !== S_IDLE || motor_en !== 1'b0 || motor_duty !== '0 || fault_latched !== 1'b0 ||
          snap_enc !== '0 || snap_hall !== '0 || snap_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got state=%0d en=%0b duty=%0d fault=%0b enc=%0d hall=%0d valid=%0b required all 0",
                  state, motor_en, motor_duty, fault_latched, snap_enc, snap_hall, snap_valid);
      end
      step(1);
      reset_n = 1'b1;
   endtask

   // Scenario sequence followed by the summary
   initial begin
      test_reset();
      test_snapshot();
      test_ramp();
      test_decrease_clamp();
      test_debounce();
      test_lockout();
      test_priority();
      test_reset_mid_ramp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bldc_motor_supervisor.md
Name: bldc_motor_supervisor

Overview:
Per-motor sequencer that sits between the SPI command/status registers and one BLDC motor instance (driver plus hall and encoder counters). It ramps the commanded duty cycle to limit startup current and debounces loss of hall connection or a hall fault. It retries with backoff and latches a lockout after repeated faults. It also takes periodic snapshots of the encoder and hall counts, clearing the motor's counters after each snapshot.

Parameters:
DUTY_CYCLE_WIDTH, 9, width of duty cycle values
MAX_DUTY_CYCLE, 'h1FF, upper clamp applied to accepted targets
ENCODER_COUNT_WIDTH, 15, width of enc_count/snap_enc
HALL_COUNT_WIDTH, 7, width of hall_count/snap_hall
RAMP_STEP, 8, duty increment per ramp tick
RAMP_TICK_CYCLES, 1024, clocks between ramp increments
SAMPLE_PERIOD_CYCLES, 18432, clocks between snapshots (1 kHz at 18.432 MHz)
DISCONNECT_DEBOUNCE, 16, consecutive clocks with connected=0 that count as a fault
RETRY_BACKOFF_CYCLES, 184320, clocks spent in BACKOFF (10 ms)
MAX_RETRIES, 3, faults tolerated before LOCKOUT

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
cmd_en  in  1  level; motor run request
cmd_valid  in  1  new target duty offered
cmd_ready  out  1  target accepted when cmd_valid & cmd_ready
cmd_duty  in  DUTY_CYCLE_WIDTH  requested target duty
clear_fault  in  1  one-cycle pulse; exits LOCKOUT
connected  in  1  motor's connected & ~fault indication
enc_count  in  ENCODER_COUNT_WIDTH  live encoder count
hall_count  in  HALL_COUNT_WIDTH  live hall count
motor_en  out  1  to motor en
motor_duty  out  DUTY_CYCLE_WIDTH  to motor duty_cycle
reset_enc_count  out  1  one-cycle counter clear
reset_hall_count  out  1  one-cycle counter clear
snap_enc  out  ENCODER_COUNT_WIDTH  last captured encoder count
snap_hall  out  HALL_COUNT_WIDTH  last captured hall count
snap_valid  out  1  one-cycle pulse; snapshot updated
state  out  3  IDLE=0, RAMP=1, RUN=2, BACKOFF=3, LOCKOUT=4
fault_latched  out  1  high only in LOCKOUT

Behaviour:
- Reset values:
  - All outputs 0, state=IDLE.
  - Target, retry count and all timers 0.
- All outputs are registered except cmd_ready.
- Command handshake:
  - cmd_ready = (state != LOCKOUT).
  - On accept, target <= min(cmd_duty, MAX_DUTY_CYCLE) in the next cycle.
  - cmd_valid while cmd_ready=0 is ignored; it is not queued.
- Ramp arithmetic:
  - Computed at DUTY_CYCLE_WIDTH+1 bits; the result never wraps.
  - On each ramp tick: if duty+RAMP_STEP >= target, duty <= target; otherwise duty <= duty+RAMP_STEP.
  - A target below the current duty takes effect on the next clock in RAMP or RUN, with no ramping down.
- IDLE:
  - motor_en=0, duty=0, retry count cleared.
  - Goes to RAMP when cmd_en=1 and connected=1.
  - The ramp tick timer restarts on entry to RAMP.
- RAMP:
  - motor_en=1; duty steps as above.
  - Goes to RUN on the cycle duty equals target.
  - target=0 goes to RUN on the first evaluation with duty 0.
- RUN:
  - motor_en=1, duty tracks target.
  - An accepted target above the current duty goes to RAMP.
- Disconnect debounce:
  - Counter increments while motor_en=1 and connected=0; it clears when connected=1.
  - When the counter reaches DISCONNECT_DEBOUNCE in RAMP or RUN: retry count +1, go to BACKOFF.
- BACKOFF:
  - motor_en=0, duty=0 on the next clock.
  - Waits RETRY_BACKOFF_CYCLES, then:
    - retry count >= MAX_RETRIES: go to LOCKOUT;
    - else connected=1 and cmd_en=1: go to RAMP from duty 0;
    - else go to IDLE.
- LOCKOUT:
  - motor_en=0, duty=0, fault_latched=1.
  - clear_fault goes to IDLE; cmd_en is ignored.
- cmd_en=0 in RAMP, RUN or BACKOFF goes to IDLE on the next clock, with duty 0 and motor_en 0 that clock. cmd_en has priority over a simultaneous fault.
- Snapshot, independent of state:
  - The sample counter counts 0..SAMPLE_PERIOD_CYCLES-1 and wraps.
  - On the terminal count T, snap_enc/snap_hall capture the live counts.
  - In cycle T+1, reset_enc_count, reset_hall_count and snap_valid are each high for exactly one cycle.
  - Edges arriving during the counter-clear cycle are lost; this is accepted.
- Asserting reset_n mid-operation returns immediately to the reset values. motor_en drops asynchronously.

Decomposition:
- Shared package bldc_pkg: state encodings, default period constants derived from the 18.432 MHz clock.
- Sub-module bldc_sample_timer: sample counter, snapshot registers and reset pulses.
- The FSM, ramp logic and debounce stay in the top module.

Test Plan:
Bench parameters: RAMP_STEP=8, RAMP_TICK_CYCLES=4, SAMPLE_PERIOD_CYCLES=100, DISCONNECT_DEBOUNCE=4, RETRY_BACKOFF_CYCLES=20, MAX_RETRIES=3.
- Ramp: cmd_en=1, target 20, connected=1 -> duty 8, 16, 20 on successive 4-cycle ticks; RUN reached on the duty=20 cycle; motor_en=1 throughout.
- Decrease and clamp: in RUN at 20, accept 5 -> duty=5 next clock, stays RUN. Accept 'h3FF with MAX_DUTY_CYCLE='h100 -> target='h100, RAMP entered.
- Debounce: connected=0 for 3 cycles -> no state change. Connected=0 for 4 cycles -> BACKOFF, motor_en=0, duty=0. After 20 cycles with connected=1 -> RAMP from 0.
- Lockout: three faults -> LOCKOUT after the third backoff; fault_latched=1, cmd_ready=0, cmd_valid ignored. clear_fault -> IDLE, retry count 0.
- Snapshot: enc_count=1234, hall_count=17 at T=99 -> snap_enc=1234, snap_hall=17; one-cycle reset_enc_count/reset_hall_count/snap_valid at cycle 100; repeats every 100 clocks.
- Reset and priority: reset_n low mid-RAMP -> all outputs 0 with no clock edge. cmd_en=0 on the same cycle as debounce expiry -> IDLE, retry count unchanged at 0.
